// File: rtl/eth_fcs_insert_if.sv
// rtl/eth_fcs_insert_if.sv - 8-bit byte stream bundle used on both sides of the FCS inserter
interface eth_fcs_insert_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/eth_fcs_insert.sv
// rtl/eth_fcs_insert.sv - Ethernet TX FCS inserter; define ETH_PAD_EN to pad short frames to MIN_FRAME_LEN
module crc32 #(
    parameter int                    LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04c11db7,
    parameter int                    DATA_WIDTH = 8
) (
    input  logic [LFSR_WIDTH-1:0] state_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [LFSR_WIDTH-1:0] state_out
);
    function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
        logic [LFSR_WIDTH-1:0] r;
        for (int i = 0; i < LFSR_WIDTH; i++) begin
            r[i] = v[LFSR_WIDTH-1-i];
        end
        return r;
    endfunction

    // Ethernet shifts bytes LSB first, so the Galois register runs in reflected form.
    localparam logic [LFSR_WIDTH-1:0] POLY_REV = reflect(LFSR_POLY);

    logic [LFSR_WIDTH-1:0] s;
    logic                  fb;

    always_comb begin
        s  = state_in;
        fb = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            fb = s[0] ^ data_in[i];
            s  = {1'b0, s[LFSR_WIDTH-1:1]} ^ (fb ? POLY_REV : '0);
        end
        state_out = s;
    end
endmodule

module eth_fcs_insert #(
    parameter int MIN_FRAME_LEN = 60,
    parameter int CNT_WIDTH     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    eth_fcs_insert_if.slave   s_axis,
    eth_fcs_insert_if.master  m_axis,
    output logic              busy
);
    if (MIN_FRAME_LEN < 1 || MIN_FRAME_LEN > 65535) begin : g_bad_min_len
        $error("MIN_FRAME_LEN out of range 1..65535");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAD  = 2'd2;
    localparam logic [1:0] ST_FCS  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]           state;
    logic [31:0]          crc;
    logic [31:0]          crc_next;
    logic [7:0]           crc_byte;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_inc;
    logic [1:0]           fcs_idx;
    logic [31:0]          fcs_word;
    logic [7:0]           fcs_byte;
    logic [1:0]           tail_state;

    logic [7:0]           m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;

    logic                 out_free;
    logic                 in_hs;

    assign out_free      = !m_tvalid || m_axis.tready;
    assign s_axis.tready = out_free && (state == ST_IDLE || state == ST_DATA);
    assign in_hs         = s_axis.tvalid && s_axis.tready;

    assign m_axis.tdata  = m_tdata;
    assign m_axis.tvalid = m_tvalid;
    assign m_axis.tlast  = m_tlast;
    assign busy          = (state != ST_IDLE);

    assign crc_byte  = (state == ST_PAD) ? 8'h00 : s_axis.tdata;
    assign count_inc = (count == CNT_MAX) ? count : count + 1'b1;

    // crc is frozen while in FCS, so inverting it in place equals latching it on entry.
    assign fcs_word  = ~crc;
    assign fcs_byte  = fcs_word[{fcs_idx, 3'b000} +: 8];

    crc32 #(
        .LFSR_WIDTH (32),
        .LFSR_POLY  (32'h04c11db7),
        .DATA_WIDTH (8)
    ) u_crc (
        .state_in  (crc),
        .data_in   (crc_byte),
        .state_out (crc_next)
    );

`ifdef ETH_PAD_EN
    localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_FRAME_LEN);

    // A saturated count never compares below MIN_CNT, so it only ever suppresses padding.
    logic short_frame;
    assign short_frame = (count_inc < MIN_CNT);
    assign tail_state  = short_frame ? ST_PAD : ST_FCS;
`else
    assign tail_state  = ST_FCS;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            crc      <= 32'hFFFFFFFF;
            count    <= '0;
            fcs_idx  <= 2'd0;
            m_tdata  <= 8'h00;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DATA: begin
                    if (in_hs) begin
                        crc   <= crc_next;
                        count <= count_inc;
                        state <= s_axis.tlast ? tail_state : ST_DATA;
                    end
                end
`ifdef ETH_PAD_EN
                ST_PAD: begin
                    if (out_free) begin
                        crc   <= crc_next;
                        count <= count_inc;
                        if (!short_frame) begin
                            state <= ST_FCS;
                        end
                    end
                end
`endif
                ST_FCS: begin
                    if (out_free) begin
                        fcs_idx <= fcs_idx + 2'd1;
                        if (fcs_idx == 2'd3) begin
                            state <= ST_IDLE;
                            crc   <= 32'hFFFFFFFF;
                            count <= '0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (out_free) begin
                if (in_hs) begin
                    m_tdata  <= s_axis.tdata;
                    m_tvalid <= 1'b1;
                    m_tlast  <= 1'b0;
`ifdef ETH_PAD_EN
                end else if (state == ST_PAD) begin
                    m_tdata  <= 8'h00;
                    m_tvalid <= 1'b1;
                    m_tlast  <= 1'b0;
`endif
                end else if (state == ST_FCS) begin
                    m_tdata  <= fcs_byte;
                    m_tvalid <= 1'b1;
                    m_tlast  <= (fcs_idx == 2'd3);
                end else begin
                    m_tvalid <= 1'b0;
                    m_tlast  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_eth_fcs_insert.sv
// tb/tb_eth_fcs_insert.sv - directed self-checking bench for eth_fcs_insert
module tb_eth_fcs_insert;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    eth_fcs_insert_if s_axis ();
    eth_fcs_insert_if m_axis ();

    eth_fcs_insert #(
        .MIN_FRAME_LEN (60),
        .CNT_WIDTH     (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_axis (s_axis),
        .m_axis (m_axis),
        .busy   (busy)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] tx_q  [$];
    logic       tl_q  [$];
    logic [7:0] out_q [$];
    logic       ol_q  [$];

    int         stall_cnt;
    int         stab_err;
    logic       last_busy;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    logic [7:0] exp_fcs [4] = '{8'h26, 8'h39, 8'hF4, 8'hCB};

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && (!m_axis.tvalid || m_axis.tdata !== prev_data || m_axis.tlast !== prev_last))
                stab_err++;
            if (m_axis.tvalid && m_axis.tready) begin
                out_q.push_back(m_axis.tdata);
                ol_q.push_back(m_axis.tlast);
                if (m_axis.tlast) last_busy = busy;
            end
            prev_stall = m_axis.tvalid && !m_axis.tready;
            prev_data  = m_axis.tdata;
            prev_last  = m_axis.tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic clear_q();
        tx_q.delete();
        tl_q.delete();
        out_q.delete();
        ol_q.delete();
        stall_cnt = 0;
        stab_err  = 0;
        last_busy = 1'b1;
    endtask

    task automatic push_check_str();
        for (int i = 0; i < 9; i++) begin
            tx_q.push_back(8'h31 + 8'(i));
            tl_q.push_back(i == 8);
        end
    endtask

    // mode 0: m_tready always high; mode 1: m_tready alternates 1,0,1,0...
    task automatic run(input int mode, input int n_out, input int budget);
        int  i   = 0;
        int  cyc = 0;
        logic hs;
        while ((i < tx_q.size() || out_q.size() < n_out) && cyc < budget) begin
            m_axis.tready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (i < tx_q.size()) begin
                s_axis.tvalid = 1'b1;
                s_axis.tdata  = tx_q[i];
                s_axis.tlast  = tl_q[i];
            end else begin
                s_axis.tvalid = 1'b0;
                s_axis.tdata  = 8'h00;
                s_axis.tlast  = 1'b0;
            end
            #1;
            if (s_axis.tvalid && !s_axis.tready) stall_cnt++;
            hs = s_axis.tvalid && s_axis.tready;
            @(posedge clk);
            #1;
            if (hs) i++;
            cyc++;
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = 8'h00;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (m_axis.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_axis.tvalid); end
        total++; if (m_axis.tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b want 0", m_axis.tlast); end
        total++; if (m_axis.tdata !== 8'h00) begin bad++; $display("FAIL reset_tdata: got %h want 00", m_axis.tdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (s_axis.tready !== 1'b1) begin bad++; $display("FAIL reset_tready: got %b want 1", s_axis.tready); end
        rst_n = 1'b1;
        s_axis.tlast = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_tlast_busy: got %b want 0", busy); end
        total++; if (m_axis.tvalid !== 1'b0) begin bad++; $display("FAIL idle_tlast_tvalid: got %b want 0", m_axis.tvalid); end
        s_axis.tlast = 1'b0;
    endtask

    task automatic test_check_string();
        int nlast;
        clear_q();
        push_check_str();
        run(0, 13, 200);
        total++; if (out_q.size() !== 13) begin bad++; $display("FAIL basic_beats: got %0d want 13", out_q.size()); end
        if (out_q.size() == 13) begin
            for (int i = 0; i < 9; i++) begin
                total++; if (out_q[i] !== 8'h31 + 8'(i)) begin bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, out_q[i], 8'h31 + 8'(i)); end
            end
            for (int i = 0; i < 4; i++) begin
                total++; if (out_q[9+i] !== exp_fcs[i]) begin bad++; $display("FAIL basic_fcs[%0d]: got %h want %h", i, out_q[9+i], exp_fcs[i]); end
            end
            nlast = 0;
            for (int i = 0; i < 13; i++) if (ol_q[i]) nlast++;
            total++; if (nlast !== 1 || ol_q[12] !== 1'b1) begin bad++; $display("FAIL basic_tlast: got count %0d last %b want 1 1", nlast, ol_q[12]); end
        end
        total++; if (last_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", last_busy); end
    endtask

`ifdef ETH_PAD_EN
    task automatic test_pad();
        logic [31:0] r;
        int          nz;
        clear_q();
        tx_q.push_back(8'hA5);
        tl_q.push_back(1'b1);
        run(0, 64, 300);
        total++; if (out_q.size() !== 64) begin bad++; $display("FAIL pad_beats: got %0d want 64", out_q.size()); end
        if (out_q.size() == 64) begin
            total++; if (out_q[0] !== 8'hA5) begin bad++; $display("FAIL pad_first: got %h want a5", out_q[0]); end
            nz = 0;
            for (int i = 1; i < 60; i++) if (out_q[i] !== 8'h00) nz++;
            total++; if (nz !== 0) begin bad++; $display("FAIL pad_zero: got %0d nonzero want 0", nz); end
            r = 32'hFFFFFFFF;
            for (int i = 0; i < 64; i++) r = crc_upd(r, out_q[i]);
            total++; if (r !== 32'hDEBB20E3) begin bad++; $display("FAIL pad_residue: got %h want debb20e3", r); end
            total++; if (ol_q[63] !== 1'b1) begin bad++; $display("FAIL pad_tlast: got %b want 1", ol_q[63]); end
        end
    endtask
`else
    task automatic test_no_pad();
        logic [7:0] exp5 [5] = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
        clear_q();
        tx_q.push_back(8'h00);
        tl_q.push_back(1'b1);
        run(0, 5, 100);
        total++; if (out_q.size() !== 5) begin bad++; $display("FAIL nopad_beats: got %0d want 5", out_q.size()); end
        if (out_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                total++; if (out_q[i] !== exp5[i]) begin bad++; $display("FAIL nopad_byte[%0d]: got %h want %h", i, out_q[i], exp5[i]); end
            end
            total++; if (ol_q[4] !== 1'b1) begin bad++; $display("FAIL nopad_tlast: got %b want 1", ol_q[4]); end
        end
    endtask
`endif

    task automatic test_backpressure();
        logic [31:0] r;
        int          nerr;
        int          nlast;
        clear_q();
        for (int i = 0; i < 64; i++) begin
            tx_q.push_back(8'(i * 37 + 5));
            tl_q.push_back(i == 63);
        end
        run(1, 68, 600);
        total++; if (out_q.size() !== 68) begin bad++; $display("FAIL bp_beats: got %0d want 68", out_q.size()); end
        if (out_q.size() == 68) begin
            nerr = 0;
            for (int i = 0; i < 64; i++) if (out_q[i] !== 8'(i * 37 + 5)) nerr++;
            total++; if (nerr !== 0) begin bad++; $display("FAIL bp_payload: got %0d wrong bytes want 0", nerr); end
            r = 32'hFFFFFFFF;
            for (int i = 0; i < 68; i++) r = crc_upd(r, out_q[i]);
            total++; if (r !== 32'hDEBB20E3) begin bad++; $display("FAIL bp_residue: got %h want debb20e3", r); end
            nlast = 0;
            for (int i = 0; i < 68; i++) if (ol_q[i]) nlast++;
            total++; if (nlast !== 1 || ol_q[67] !== 1'b1) begin bad++; $display("FAIL bp_tlast: got count %0d last %b want 1 1", nlast, ol_q[67]); end
        end
        total++; if (stab_err !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", stab_err); end
    endtask

    task automatic test_back_to_back();
        clear_q();
        push_check_str();
        push_check_str();
        run(0, 26, 300);
        total++; if (out_q.size() !== 26) begin bad++; $display("FAIL b2b_beats: got %0d want 26", out_q.size()); end
        if (out_q.size() == 26) begin
            for (int i = 0; i < 4; i++) begin
                total++; if (out_q[9+i] !== exp_fcs[i]) begin bad++; $display("FAIL b2b_fcs1[%0d]: got %h want %h", i, out_q[9+i], exp_fcs[i]); end
                total++; if (out_q[22+i] !== exp_fcs[i]) begin bad++; $display("FAIL b2b_fcs2[%0d]: got %h want %h", i, out_q[22+i], exp_fcs[i]); end
            end
            total++; if (out_q[13] !== 8'h31) begin bad++; $display("FAIL b2b_second_first: got %h want 31", out_q[13]); end
        end
        total++; if (stall_cnt !== 4) begin bad++; $display("FAIL b2b_tready_low: got %0d want 4", stall_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        clear_q();
        m_axis.tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = 8'h31 + 8'(i);
            s_axis.tlast  = 1'b0;
            @(posedge clk);
            #1;
        end
        s_axis.tvalid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++; if (m_axis.tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_tvalid: got %b want 0", m_axis.tvalid); end
        total++; if (m_axis.tdata !== 8'h00) begin bad++; $display("FAIL mid_rst_tdata: got %h want 00", m_axis.tdata); end
        total++; if (m_axis.tlast !== 1'b0) begin bad++; $display("FAIL mid_rst_tlast: got %b want 0", m_axis.tlast); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        clear_q();
        push_check_str();
        run(0, 13, 200);
        total++; if (out_q.size() !== 13) begin bad++; $display("FAIL mid_rst_beats: got %0d want 13", out_q.size()); end
        if (out_q.size() == 13) begin
            for (int i = 0; i < 4; i++) begin
                total++; if (out_q[9+i] !== exp_fcs[i]) begin bad++; $display("FAIL mid_rst_fcs[%0d]: got %h want %h", i, out_q[9+i], exp_fcs[i]); end
            end
        end
    endtask

    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = 8'h00;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b1;
        test_reset();
        test_check_string();
`ifdef ETH_PAD_EN
        test_pad();
`else
        test_no_pad();
`endif
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
